instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0040_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port imem_req, output, 1 bit: read request to instruction memory.
REQ-005 The block SHALL have port imem_addr, output, 32 bits: word-aligned fetch address, stable while imem_req=1.
REQ-006 The block SHALL have port imem_ack, input, 1 bit: memory response valid; ignored when imem_req=0.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: instruction word, valid with imem_ack.
REQ-008 The block SHALL have port stall, input, 1 bit: decode stage cannot accept; outputs hold.
REQ-009 The block SHALL have port redirect, input, 1 bit: branch/jump taken, flush and refetch.
REQ-010 The block SHALL have port redirect_pc, input, 32 bits: redirect target.
REQ-011 The block SHALL have port instruction_out, output, 32 bits: fetched instruction toward the IF/ID register.
REQ-012 The block SHALL have port pc_out, output, 32 bits: fetch address of instruction_out plus 4.
REQ-013 The block SHALL have port valid_out, output, 1 bit: instruction_out/pc_out hold a live instruction.

Function
REQ-014 FSM states SHALL be IDLE, REQUEST, HOLD; an internal 32-bit register pc holds the next fetch address.
REQ-015 IDLE SHALL last exactly one cycle with imem_req=0, then go to REQUEST.
REQ-016 In REQUEST the block SHALL drive imem_req=1 and imem_addr=pc until imem_ack, with imem_addr unchanged across wait cycles.
REQ-017 On imem_ack in REQUEST with the output slot free, the block SHALL register instruction_out=imem_rdata, pc_out=pc+4, valid_out=1, and pc<=pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-018 The output slot SHALL be free when valid_out=0 or stall=0; a valid output with stall=0 is consumed at that edge.
REQ-019 If valid_out=1 and stall=1, instruction_out, pc_out and valid_out SHALL hold unchanged.
REQ-020 If the slot is consumed at an edge with no new instruction arriving, valid_out SHALL fall to 0.
REQ-021 The FSM SHALL enter HOLD when valid_out=1, stall=1 and no further fetch can be accepted, drive imem_req=0 there, and return to REQUEST the cycle after stall=0.
REQ-022 Redirect SHALL have top priority in every state: pc<=redirect_pc with bits [1:0] forced to 0, valid_out<=0, buffer emptied, any same-cycle imem_ack data discarded, and next state REQUEST.
REQ-023 Redirect and stall in the same cycle SHALL still flush the outputs.
REQ-024 Back-to-back single-cycle acks with stall=0 SHALL yield one instruction per cycle, with latency 1 cycle from imem_ack to valid_out.

Reset
REQ-025 While reset=1 at a clock edge, the block SHALL set the FSM to IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instruction_out=0, pc_out=0, valid_out=0, and the buffer empty.
REQ-026 Reset SHALL take priority over redirect and abandon any outstanding request.
REQ-027 The first imem_req SHALL assert 2 cycles after reset deasserts (IDLE, then REQUEST).

Configuration
REQ-028 With macro FETCH_BUFFER_EN defined, a one-entry buffer (instruction plus pc+4) SHALL allow one further fetch while the output is held; HOLD is entered only when the buffer is full. On release, the buffer moves to the outputs before any new ack.
REQ-029 Without FETCH_BUFFER_EN, no buffer SHALL exist; HOLD is entered on the first cycle with valid_out=1 and stall=1, and no request is issued while held.

Verification
REQ-030 Scenario: reset, then ack every cycle with rdata=addr^32'hA5A5_A5A5 -> first imem_addr=32'h0040_0000; pc_out sequence 32'h0040_0004, 0008, 000C; valid_out continuous.
REQ-031 Scenario: stall=1 for 3 cycles while valid_out=1 -> outputs frozen 3 cycles; without the macro imem_req=0 during the stall; with it exactly one extra ack is accepted, then imem_req=0.
REQ-032 Scenario: redirect=1, redirect_pc=32'h0040_0103, same cycle as imem_ack -> next cycle valid_out=0, then imem_addr=32'h0040_0100; the acked data never appears.
REQ-033 Scenario: ack delayed 4 cycles -> imem_addr stable for all 5 request cycles; valid_out=0 until the cycle after the ack.
REQ-034 Scenario: redirect_pc=32'hFFFF_FFFC then acks -> pc_out=32'h0000_0000, next fetch at 32'h0000_0000.
REQ-035 Scenario: reset=1 mid-wait with stall=1 and buffer full -> all outputs at reset values next cycle; refetch from RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding fetch FSM (IDLE/REQUEST/HOLD) feeding the IF/ID register.
// Optional macro FETCH_BUFFER_EN adds a one-entry buffer so one extra fetch can complete while decode stalls.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        valid_out
);
    typedef enum logic [1:0] {IDLE, REQUEST, HOLD} state_t;
    state_t      r_state;
    logic        r_req;
    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
`ifdef FETCH_BUFFER_EN
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc;
`endif
    logic        w_free;
    logic [31:0] w_pc_inc;

    assign w_free          = !r_valid || !stall;
    assign w_pc_inc        = r_pc + 32'd4;
    assign imem_req        = r_req;
    assign imem_addr       = r_pc;
    assign instruction_out = r_instr;
    assign pc_out          = r_pc_out;
    assign valid_out       = r_valid;

    // Fetch FSM: reset beats redirect, redirect beats everything else; HOLD means the held output cannot take more
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_req    <= 1'b0;
            r_pc     <= RESET_PC;
            r_instr  <= 32'd0;
            r_pc_out <= 32'd0;
            r_valid  <= 1'b0;
`ifdef FETCH_BUFFER_EN
            r_buf_instr <= 32'd0;
            r_buf_pc    <= 32'd0;
`endif
        end else if (redirect) begin
            r_state <= REQUEST;
            r_req   <= 1'b1;
            r_pc    <= redirect_pc & ~32'd3;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= REQUEST;
                    r_req   <= 1'b1;
                end
                REQUEST: begin
                    if (imem_ack && w_free) begin
                        r_instr  <= imem_rdata;
                        r_pc_out <= w_pc_inc;
                        r_valid  <= 1'b1;
                        r_pc     <= w_pc_inc;
                    end else if (w_free) begin
                        r_valid <= 1'b0;
                    end else begin
`ifdef FETCH_BUFFER_EN
                        if (imem_ack) begin
                            r_buf_instr <= imem_rdata;
                            r_buf_pc    <= w_pc_inc;
                            r_pc        <= w_pc_inc;
                            r_state     <= HOLD;
                            r_req       <= 1'b0;
                        end
`else
                        r_state <= HOLD;
                        r_req   <= 1'b0;
`endif
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        r_state <= REQUEST;
                        r_req   <= 1'b1;
`ifdef FETCH_BUFFER_EN
                        r_instr  <= r_buf_instr;
                        r_pc_out <= r_buf_pc;
                        r_valid  <= 1'b1;
`else
                        r_valid  <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed stimulus with a scoreboard queue checked by an independent output monitor.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_ack = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic        valid_out;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    logic        prev_hold = 1'b0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hA5A5_A5A5;

    instruction_fetch dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .instruction_out(instruction_out),
        .pc_out(pc_out),
        .valid_out(valid_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        exp_q.push_back({a ^ 32'hA5A5_A5A5, a + 32'd4});
    endtask

    task automatic step(input logic a, input logic s, input logic r, input logic [31:0] rp);
        imem_ack    = a;
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every newly presented instruction must match the oldest expected entry
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (valid_out && !prev_hold) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output actual=%h/%h required=none", instruction_out, pc_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({instruction_out, pc_out} !== mon_exp) begin
                        errors++;
                        $display("FAIL output_data actual=%h/%h required=%h/%h",
                                 instruction_out, pc_out, mon_exp[63:32], mon_exp[31:0]);
                    end
                end
            end
            prev_hold = valid_out && stall && !redirect;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", imem_req, 32'd0);
        chk("rst_addr", imem_addr, 32'h0040_0000);
        chk("rst_instr", instruction_out, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_valid", valid_out, 32'd0);
        reset = 1'b0;
        chk("idle_req", imem_req, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        chk("first_req", imem_req, 32'd1);
        chk("first_addr", imem_addr, 32'h0040_0000);
        for (int i = 0; i < 4; i++) begin
            push(32'h0040_0000 + 32'(4 * i));
            step(1'b1, 1'b0, 1'b0, 32'd0);
            chk("stream_valid", valid_out, 32'd1);
        end
        chk("stall0_pc_out", pc_out, 32'h0040_0010);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("stall1_req", imem_req, 32'd0);
        chk("stall1_pc_out", pc_out, 32'h0040_0010);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("stall2_req", imem_req, 32'd0);
        chk("stall2_pc_out", pc_out, 32'h0040_0010);
        chk("stall2_instr", instruction_out, 32'h0040_000C ^ 32'hA5A5_A5A5);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("release_req", imem_req, 32'd0);
        chk("release_pc_out", pc_out, 32'h0040_0010);
        chk("release_valid", valid_out, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("wait_addr", imem_addr, 32'h0040_0010);
            chk("wait_valid", valid_out, 32'd0);
            step(1'b0, 1'b0, 1'b0, 32'd0);
        end
        chk("wait_addr_ack", imem_addr, 32'h0040_0010);
        chk("wait_valid_ack", valid_out, 32'd0);
        push(32'h0040_0010);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        chk("late_valid", valid_out, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("pre_redir_addr", imem_addr, 32'h0040_0014);
        step(1'b1, 1'b0, 1'b1, 32'h0040_0103);
        chk("redir_valid", valid_out, 32'd0);
        chk("redir_addr", imem_addr, 32'h0040_0100);
        chk("redir_req", imem_req, 32'd1);
        push(32'h0040_0100);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        chk("wrap_pc_out", pc_out, 32'd0);
        chk("wrap_addr", imem_addr, 32'd0);
        push(32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        chk("pre_flush_valid", valid_out, 32'd1);
        step(1'b0, 1'b1, 1'b1, 32'h0040_0200);
        chk("flush_valid", valid_out, 32'd0);
        chk("flush_addr", imem_addr, 32'h0040_0200);
        push(32'h0040_0200);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        chk("held_valid", valid_out, 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        reset = 1'b1;
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("rst2_req", imem_req, 32'd0);
        chk("rst2_addr", imem_addr, 32'h0040_0000);
        chk("rst2_instr", instruction_out, 32'd0);
        chk("rst2_pc_out", pc_out, 32'd0);
        chk("rst2_valid", valid_out, 32'd0);
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0, 32'd0);
        chk("refetch_req", imem_req, 32'd1);
        chk("refetch_addr", imem_addr, 32'h0040_0000);
        push(32'h0040_0000);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
